vram_draw_controller: RTL

VRAM_DRAW_CONTROLLER -- requirements
Module: vram_draw_controller

---
 rtl/vram_draw_controller.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/vram_draw_controller.sv
// vram_draw_controller
//
// Drives the write port of a frame-buffer block RAM. After reset the whole buffer
// is filled with a latched color. From idle it then either repeats the full-screen
// fill (clear_req) or paints a square brush stroke (touch_valid) centered on
// (touch_x, touch_y). The stroke visits (2s+1)^2 candidate pixels in raster order.
// Candidates that fall off the screen use up their cycle without writing.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   clear_req      level request for a full-screen fill with clear_color
//   clear_color    fill color
//   touch_valid    stroke request qualifier
//   touch_x/y      stroke center
//   brush_size     brush half-size s, clamped to BRUSH_MAX
//   pen_color      stroke color
//   vram_wr_*      registered block-RAM write port (enable, address, data)
//   busy           fill or stroke in progress
//   clearing       fill in progress
//   draw_done      one-cycle pulse after the last stroke pixel
//
// Optional feature: define VRAM_DRAW_DEDUP_EN to drop a touch that exactly repeats
// the last completed stroke. Any clear or reset forgets that stroke.

module vram_draw_controller #(
    parameter int unsigned DISPLAY_WIDTH  = 240,
    parameter int unsigned DISPLAY_HEIGHT = 320,
    parameter int unsigned VRAM_W         = 16,
    parameter int unsigned BRUSH_MAX      = 7,
    localparam int unsigned VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int unsigned AW     = $clog2(VRAM_L),
    localparam int unsigned XW     = $clog2(DISPLAY_WIDTH),
    localparam int unsigned YW     = $clog2(DISPLAY_HEIGHT),
    localparam int unsigned BW     = $clog2(BRUSH_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic [VRAM_W-1:0] clear_color,
    input  logic              touch_valid,
    input  logic [XW-1:0]     touch_x,
    input  logic [YW-1:0]     touch_y,
    input  logic [BW-1:0]     brush_size,
    input  logic [VRAM_W-1:0] pen_color,
    output logic              vram_wr_ena,
    output logic [AW-1:0]     vram_wr_addr,
    output logic [VRAM_W-1:0] vram_wr_data,
    output logic              busy,
    output logic              clearing,
    output logic              draw_done
);

    // Candidate coordinates use an extra sign bit plus headroom. A negative value
    // therefore reads as a huge unsigned number, and one unsigned compare covers
    // both edges of the screen.
    localparam int unsigned CW = ((XW > YW) ? XW : YW) + BW + 2;

    typedef enum logic [1:0] {
        StClearing,
        StIdle,
        StDrawing
    } state_e;

    state_e              state_q;
    logic [AW-1:0]       clr_cnt_q;
    logic [VRAM_W-1:0]   fill_color_q;
    logic [XW-1:0]       cur_x_q;
    logic [YW-1:0]       cur_y_q;
    logic [BW-1:0]       cur_s_q;
    logic [VRAM_W-1:0]   cur_color_q;
    logic [BW:0]         off_x_q;
    logic [BW:0]         off_y_q;
    logic                done_pend_q;

`ifdef VRAM_DRAW_DEDUP_EN
    logic                hist_valid_q;
    logic [XW-1:0]       hist_x_q;
    logic [YW-1:0]       hist_y_q;
    logic [BW-1:0]       hist_s_q;
    logic [VRAM_W-1:0]   hist_color_q;
`endif

    logic [BW-1:0]       s_clamp_c;
    logic [BW:0]         span_c;
    logic [CW-1:0]       px_c;
    logic [CW-1:0]       py_c;
    logic                in_range_c;
    logic [AW-1:0]       addr_c;
    logic                last_c;
    logic                dup_c;

    always_comb begin
        s_clamp_c = (brush_size > BW'(BRUSH_MAX)) ? BW'(BRUSH_MAX) : brush_size;
        span_c    = {cur_s_q, 1'b0};
        // Offsets run 0..2s, so the candidate is center + offset - s.
        px_c       = CW'(cur_x_q) + CW'(off_x_q) - CW'(cur_s_q);
        py_c       = CW'(cur_y_q) + CW'(off_y_q) - CW'(cur_s_q);
        in_range_c = (px_c < CW'(DISPLAY_WIDTH)) && (py_c < CW'(DISPLAY_HEIGHT));
        // Only meaningful when in range, where the value is below VRAM_L.
        addr_c     = AW'(py_c) * AW'(DISPLAY_WIDTH) + AW'(px_c);
        last_c     = (off_x_q == span_c) && (off_y_q == span_c);
        dup_c      = 1'b0;
`ifdef VRAM_DRAW_DEDUP_EN
        dup_c = hist_valid_q && (touch_x == hist_x_q) && (touch_y == hist_y_q) &&
                (s_clamp_c == hist_s_q) && (pen_color == hist_color_q);
`endif
    end

    // busy and clearing follow the write port. They rise on the cycle a request is
    // accepted and stay high through the cycle that shows the final write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StClearing;
            clr_cnt_q    <= '0;
            fill_color_q <= clear_color;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cur_s_q      <= '0;
            cur_color_q  <= '0;
            off_x_q      <= '0;
            off_y_q      <= '0;
            done_pend_q  <= 1'b0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            busy         <= 1'b1;
            clearing     <= 1'b1;
            draw_done    <= 1'b0;
`ifdef VRAM_DRAW_DEDUP_EN
            hist_valid_q <= 1'b0;
            hist_x_q     <= '0;
            hist_y_q     <= '0;
            hist_s_q     <= '0;
            hist_color_q <= '0;
`endif
        end else begin
            vram_wr_ena <= 1'b0;
            draw_done   <= 1'b0;
            done_pend_q <= 1'b0;
            busy        <= (state_q != StIdle);
            clearing    <= (state_q == StClearing);

            unique case (state_q)
                StClearing: begin
                    vram_wr_ena  <= 1'b1;
                    vram_wr_addr <= clr_cnt_q;
                    vram_wr_data <= fill_color_q;
                    if (clr_cnt_q == AW'(VRAM_L - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + AW'(1);
                    end
                end

                StIdle: begin
                    draw_done <= done_pend_q;
                    if (clear_req) begin
                        state_q      <= StClearing;
                        clr_cnt_q    <= '0;
                        fill_color_q <= clear_color;
                        busy         <= 1'b1;
                        clearing     <= 1'b1;
`ifdef VRAM_DRAW_DEDUP_EN
                        hist_valid_q <= 1'b0;
`endif
                    end else if (touch_valid && !dup_c) begin
                        state_q     <= StDrawing;
                        cur_x_q     <= touch_x;
                        cur_y_q     <= touch_y;
                        cur_s_q     <= s_clamp_c;
                        cur_color_q <= pen_color;
                        off_x_q     <= '0;
                        off_y_q     <= '0;
                        busy        <= 1'b1;
                    end
                end

                StDrawing: begin
                    if (clear_req) begin
                        // Abort: the fill starts on this edge, so address 0 is written
                        // immediately with the newly sampled color.
                        fill_color_q <= clear_color;
                        vram_wr_ena  <= 1'b1;
                        vram_wr_addr <= '0;
                        vram_wr_data <= clear_color;
                        clearing     <= 1'b1;
`ifdef VRAM_DRAW_DEDUP_EN
                        hist_valid_q <= 1'b0;
`endif
                        if (VRAM_L == 1) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StClearing;
                            clr_cnt_q <= AW'(1);
                        end
                    end else begin
                        vram_wr_ena  <= in_range_c;
                        vram_wr_addr <= addr_c;
                        vram_wr_data <= cur_color_q;
                        if (last_c) begin
                            state_q     <= StIdle;
                            done_pend_q <= 1'b1;
`ifdef VRAM_DRAW_DEDUP_EN
                            hist_valid_q <= 1'b1;
                            hist_x_q     <= cur_x_q;
                            hist_y_q     <= cur_y_q;
                            hist_s_q     <= cur_s_q;
                            hist_color_q <= cur_color_q;
`endif
                        end else if (off_x_q == span_c) begin
                            off_x_q <= '0;
                            off_y_q <= off_y_q + 1'b1;
                        end else begin
                            off_x_q <= off_x_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q   <= StClearing;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule
